// File: rtl/riesgos_pkg.sv
// rtl/riesgos_pkg.sv - shared types and encodings for the hazard unit
// Purpose: hazard-unit FSM state enum, operand-forwarding select encodings
//          and the width of the load-use bubble down-counter.
// Ports: none (package).
package riesgos_pkg;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    LU_WAIT  = 2'd1,
    MEM_WAIT = 2'd2
  } estado_e;

  // Operand source select: register file, memory stage, writeback stage.
  localparam logic [1:0] FOR_RF  = 2'b00;
  localparam logic [1:0] FOR_MEM = 2'b10;
  localparam logic [1:0] FOR_WB  = 2'b01;

  // Enough bits to hold LOAD_LAT-1 for LOAD_LAT up to 8.
  localparam int CNT_BITS = 3;

endpackage

// File: rtl/sel_adelanto.sv
// rtl/sel_adelanto.sv - forwarding source select for one execute operand
// Purpose: picks where one execute-stage source operand comes from.
// Ports:
//   src            in  REG_W  source register of the operand in execute
//   rd_mem/esc_mem in  REG_W/1 memory-stage destination and write enable
//   load_mem       in  1      memory-stage instruction is a load
//   rd_wb/esc_wb   in  REG_W/1 writeback destination and write enable
//   sel            out 2      FOR_RF / FOR_MEM / FOR_WB
module sel_adelanto
  import riesgos_pkg::*;
#(
  parameter int REG_W = 5
) (
  input  logic [REG_W-1:0] src,
  input  logic [REG_W-1:0] rd_mem,
  input  logic             esc_mem,
  input  logic             load_mem,
  input  logic [REG_W-1:0] rd_wb,
  input  logic             esc_wb,
  output logic [1:0]       sel
);

  always_comb begin
    sel = FOR_RF;
    // The memory stage holds the most recent value, so it is tested first.
    // A load in the memory stage has no data yet; the load-use stall covers it.
    if (esc_mem && !load_mem && (rd_mem != '0) && (rd_mem == src)) begin
      sel = FOR_MEM;
    end else if (esc_wb && (rd_wb != '0) && (rd_wb == src)) begin
      sel = FOR_WB;
    end
  end

endmodule

// File: rtl/unidad_riesgos.sv
// rtl/unidad_riesgos.sv - pipeline hazard unit: forwarding, stalls, flushes
// Purpose: forwarding selects for the execute operands, load-use and
//          memory-wait stall sequencing, branch flushes, perf counters.
// Ports:
//   clk, reset                         clock, synchronous active-high reset
//   rs_id, rt_id                       decode-stage sources
//   rs_ex, rt_ex                       execute-stage sources
//   rd_ex, esc_ex, load_ex             execute destination / write / load
//   rd_mem, esc_mem, load_mem          memory destination / write / load
//   rd_wb, esc_wb                      writeback destination / write
//   branch_ex, mem_busy                taken branch in execute, dmem not ready
//   for_a, for_b                       operand source selects
//   stall_if/id/ex/mem                 hold pipeline registers
//   flush_ifid, bubble_idex/memwb      insert NOPs
//   stall_cnt, flush_cnt               saturating performance counters
module unidad_riesgos
  import riesgos_pkg::*;
#(
  parameter int REG_W    = 5,
  parameter int LOAD_LAT = 1,
  parameter int CNT_W    = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [REG_W-1:0] rs_id,
  input  logic [REG_W-1:0] rt_id,
  input  logic [REG_W-1:0] rs_ex,
  input  logic [REG_W-1:0] rt_ex,
  input  logic [REG_W-1:0] rd_ex,
  input  logic             esc_ex,
  input  logic             load_ex,
  input  logic [REG_W-1:0] rd_mem,
  input  logic             esc_mem,
  input  logic             load_mem,
  input  logic [REG_W-1:0] rd_wb,
  input  logic             esc_wb,
  input  logic             branch_ex,
  input  logic             mem_busy,
  output logic [1:0]       for_a,
  output logic [1:0]       for_b,
  output logic             stall_if,
  output logic             stall_id,
  output logic             stall_ex,
  output logic             stall_mem,
  output logic             flush_ifid,
  output logic             bubble_idex,
  output logic             bubble_memwb,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  // Bubbles still owed after the one issued in the detecting RUN cycle.
  localparam logic [CNT_BITS-1:0] LU_INIT = CNT_BITS'(LOAD_LAT - 1);

  estado_e             state_q, state_d;
  logic [CNT_BITS-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0]    stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0]    flush_cnt_q, flush_cnt_d;
  logic [1:0]          sel_a, sel_b;
  logic                lu_det;

  sel_adelanto #(.REG_W(REG_W)) u_sel_a (
    .src      (rs_ex),
    .rd_mem   (rd_mem),
    .esc_mem  (esc_mem),
    .load_mem (load_mem),
    .rd_wb    (rd_wb),
    .esc_wb   (esc_wb),
    .sel      (sel_a)
  );

  sel_adelanto #(.REG_W(REG_W)) u_sel_b (
    .src      (rt_ex),
    .rd_mem   (rd_mem),
    .esc_mem  (esc_mem),
    .load_mem (load_mem),
    .rd_wb    (rd_wb),
    .esc_wb   (esc_wb),
    .sel      (sel_b)
  );

  assign for_a = reset ? FOR_RF : sel_a;
  assign for_b = reset ? FOR_RF : sel_b;

  assign lu_det = load_ex && esc_ex && (rd_ex != '0) &&
                  ((rd_ex == rs_id) || (rd_ex == rt_id));

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    stall_if     = 1'b0;
    stall_id     = 1'b0;
    stall_ex     = 1'b0;
    stall_mem    = 1'b0;
    flush_ifid   = 1'b0;
    bubble_idex  = 1'b0;
    bubble_memwb = 1'b0;

    case (state_q)
      RUN: begin
        if (mem_busy) begin
          {stall_if, stall_id, stall_ex, stall_mem, bubble_memwb} = '1;
          state_d = MEM_WAIT;
        end else if (branch_ex) begin
          // The wrong-path instruction in decode is squashed, so any
          // load-use hazard it carries is moot.
          flush_ifid  = 1'b1;
          bubble_idex = 1'b1;
        end else if (lu_det) begin
          stall_if    = 1'b1;
          stall_id    = 1'b1;
          bubble_idex = 1'b1;
          if (LOAD_LAT > 1) begin
            state_d = LU_WAIT;
            cnt_d   = LU_INIT;
          end
        end
      end

      LU_WAIT: begin
        if (mem_busy) begin
          // Bubble count is frozen while memory holds the whole pipe.
          {stall_if, stall_id, stall_ex, stall_mem, bubble_memwb} = '1;
          state_d = MEM_WAIT;
        end else if (branch_ex) begin
          flush_ifid  = 1'b1;
          bubble_idex = 1'b1;
          state_d     = RUN;
          cnt_d       = '0;
        end else begin
          stall_if    = 1'b1;
          stall_id    = 1'b1;
          bubble_idex = 1'b1;
          if (cnt_q <= CNT_BITS'(1)) begin
            state_d = RUN;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q - CNT_BITS'(1);
          end
        end
      end

      MEM_WAIT: begin
        // A branch in execute is held in place by stall_ex and is acted on
        // once the memory wait is over.
        if (mem_busy) begin
          {stall_if, stall_id, stall_ex, stall_mem, bubble_memwb} = '1;
        end else begin
          state_d = (cnt_q != '0) ? LU_WAIT : RUN;
        end
      end

      default: begin
        state_d = RUN;
        cnt_d   = '0;
      end
    endcase

    if (reset) begin
      stall_if     = 1'b0;
      stall_id     = 1'b0;
      stall_ex     = 1'b0;
      stall_mem    = 1'b0;
      flush_ifid   = 1'b0;
      bubble_idex  = 1'b0;
      bubble_memwb = 1'b0;
    end

    stall_cnt_d = stall_cnt_q;
    if (stall_id && (stall_cnt_q != '1)) begin
      stall_cnt_d = stall_cnt_q + CNT_W'(1);
    end
    flush_cnt_d = flush_cnt_q;
    if (flush_ifid && (flush_cnt_q != '1)) begin
      flush_cnt_d = flush_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= RUN;
      cnt_q       <= '0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign stall_cnt = stall_cnt_q;
  assign flush_cnt = flush_cnt_q;

endmodule

// File: tb/tb_unidad_riesgos.sv
// tb/tb_unidad_riesgos.sv - scoreboard bench for unidad_riesgos
module tb_unidad_riesgos;

  logic       clk = 1'b0;
  logic       reset;
  logic [4:0] rs_id, rt_id, rs_ex, rt_ex, rd_ex, rd_mem, rd_wb;
  logic       esc_ex, load_ex, esc_mem, load_mem, esc_wb, branch_ex, mem_busy;

  logic [1:0]  d0_for_a, d0_for_b, d1_for_a, d1_for_b;
  logic        d0_sif, d0_sid, d0_sex, d0_smem, d0_fl, d0_bidex, d0_bmw;
  logic        d1_sif, d1_sid, d1_sex, d1_smem, d1_fl, d1_bidex, d1_bmw;
  logic [3:0]  d0_scnt, d0_fcnt;
  logic [15:0] d1_scnt, d1_fcnt;

  always #5 clk = ~clk;

  // dut0: single-bubble loads, narrow counters; dut1: three-bubble loads.
  unidad_riesgos #(.REG_W(5), .LOAD_LAT(1), .CNT_W(4)) dut0 (
    .clk(clk), .reset(reset), .rs_id(rs_id), .rt_id(rt_id),
    .rs_ex(rs_ex), .rt_ex(rt_ex), .rd_ex(rd_ex), .esc_ex(esc_ex),
    .load_ex(load_ex), .rd_mem(rd_mem), .esc_mem(esc_mem),
    .load_mem(load_mem), .rd_wb(rd_wb), .esc_wb(esc_wb),
    .branch_ex(branch_ex), .mem_busy(mem_busy),
    .for_a(d0_for_a), .for_b(d0_for_b),
    .stall_if(d0_sif), .stall_id(d0_sid), .stall_ex(d0_sex),
    .stall_mem(d0_smem), .flush_ifid(d0_fl), .bubble_idex(d0_bidex),
    .bubble_memwb(d0_bmw), .stall_cnt(d0_scnt), .flush_cnt(d0_fcnt)
  );

  unidad_riesgos #(.REG_W(5), .LOAD_LAT(3), .CNT_W(16)) dut1 (
    .clk(clk), .reset(reset), .rs_id(rs_id), .rt_id(rt_id),
    .rs_ex(rs_ex), .rt_ex(rt_ex), .rd_ex(rd_ex), .esc_ex(esc_ex),
    .load_ex(load_ex), .rd_mem(rd_mem), .esc_mem(esc_mem),
    .load_mem(load_mem), .rd_wb(rd_wb), .esc_wb(esc_wb),
    .branch_ex(branch_ex), .mem_busy(mem_busy),
    .for_a(d1_for_a), .for_b(d1_for_b),
    .stall_if(d1_sif), .stall_id(d1_sid), .stall_ex(d1_sex),
    .stall_mem(d1_smem), .flush_ifid(d1_fl), .bubble_idex(d1_bidex),
    .bubble_memwb(d1_bmw), .stall_cnt(d1_scnt), .flush_cnt(d1_fcnt)
  );

  typedef struct {
    int         step;
    int         sel;
    logic [1:0] fa;
    logic [1:0] fb;
    logic [3:0] st;   // {stall_if, stall_id, stall_ex, stall_mem}
    logic [2:0] fl;   // {flush_ifid, bubble_idex, bubble_memwb}
    bit         chk;
    int         sc;
    int         fc;
  } exp_t;

  exp_t exp_q[$];
  int   checks   = 0;
  int   failures = 0;
  int   step     = 0;

  task automatic check(input int stp, input int sel, input string what,
                       input int act, input int req);
    checks++;
    if (act != req) begin
      failures++;
      $display("FAIL step%0d dut%0d %s actual=%0d required=%0d",
               stp, sel, what, act, req);
    end
  endtask

  // Monitor: outputs are valid every cycle, so each expectation queued for
  // the current cycle is compared on the falling edge.
  initial begin
    exp_t       e;
    logic [1:0] afa, afb;
    logic [3:0] ast;
    logic [2:0] afl;
    int         asc, afc;
    forever begin
      @(negedge clk);
      while (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        if (e.sel == 0) begin
          afa = d0_for_a; afb = d0_for_b;
          ast = {d0_sif, d0_sid, d0_sex, d0_smem};
          afl = {d0_fl, d0_bidex, d0_bmw};
          asc = int'(d0_scnt); afc = int'(d0_fcnt);
        end else begin
          afa = d1_for_a; afb = d1_for_b;
          ast = {d1_sif, d1_sid, d1_sex, d1_smem};
          afl = {d1_fl, d1_bidex, d1_bmw};
          asc = int'(d1_scnt); afc = int'(d1_fcnt);
        end
        check(e.step, e.sel, "for_a", int'(afa), int'(e.fa));
        check(e.step, e.sel, "for_b", int'(afb), int'(e.fb));
        check(e.step, e.sel, "stalls", int'(ast), int'(e.st));
        check(e.step, e.sel, "flush_bubbles", int'(afl), int'(e.fl));
        if (e.chk) begin
          check(e.step, e.sel, "stall_cnt", asc, e.sc);
          check(e.step, e.sel, "flush_cnt", afc, e.fc);
        end
      end
    end
  end

  task automatic expect_out(input int sel, input logic [1:0] fa, input logic [1:0] fb,
                            input logic [3:0] st, input logic [2:0] fl,
                            input bit chk, input int sc, input int fc);
    exp_t e;
    e.step = step; e.sel = sel; e.fa = fa; e.fb = fb; e.st = st; e.fl = fl;
    e.chk = chk; e.sc = sc; e.fc = fc;
    exp_q.push_back(e);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    step++;
  endtask

  task automatic clr();
    rs_id = 0; rt_id = 0; rs_ex = 0; rt_ex = 0; rd_ex = 0; rd_mem = 0; rd_wb = 0;
    esc_ex = 0; load_ex = 0; esc_mem = 0; load_mem = 0; esc_wb = 0;
    branch_ex = 0; mem_busy = 0;
  endtask

  task automatic hazard(input logic [4:0] r);
    load_ex = 1; esc_ex = 1; rd_ex = r; rs_id = r;
  endtask

  // One cycle against dut1 with stall/flush expectations and counters.
  task automatic s1(input logic [3:0] st, input logic [2:0] fl, input int sc, input int fc);
    expect_out(1, 2'b00, 2'b00, st, fl, 1, sc, fc);
    tick();
  endtask

  task automatic reset_cycle();
    clr();
    reset = 1; hazard(5'd7); mem_busy = 1; branch_ex = 1;
    rs_ex = 3; rd_mem = 3; esc_mem = 1;
    expect_out(0, 2'b00, 2'b00, 4'b0000, 3'b000, 0, 0, 0);
    expect_out(1, 2'b00, 2'b00, 4'b0000, 3'b000, 0, 0, 0);
    tick();
    reset = 0; clr();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1; clr();
    tick();

    // Outputs forced quiet during reset, counters zero right after.
    reset_cycle();
    expect_out(0, 2'b00, 2'b00, 4'b0000, 3'b000, 1, 0, 0);
    expect_out(1, 2'b00, 2'b00, 4'b0000, 3'b000, 1, 0, 0);
    tick();

    // Forwarding (no hazards, FSM stays idle).
    clr(); rs_ex = 3; rd_mem = 3; esc_mem = 1; rd_wb = 3; esc_wb = 1;
    expect_out(0, 2'b10, 2'b00, 4'b0000, 3'b000, 1, 0, 0); tick();
    esc_mem = 0;
    expect_out(0, 2'b01, 2'b00, 4'b0000, 3'b000, 0, 0, 0); tick();
    clr(); esc_mem = 1; esc_wb = 1;
    expect_out(0, 2'b00, 2'b00, 4'b0000, 3'b000, 0, 0, 0); tick();
    clr(); rs_ex = 3; rt_ex = 3; rd_mem = 3; esc_mem = 1; load_mem = 1; rd_wb = 3; esc_wb = 1;
    expect_out(0, 2'b01, 2'b01, 4'b0000, 3'b000, 0, 0, 0); tick();
    clr(); rt_ex = 9; rd_mem = 9; esc_mem = 1; rs_ex = 4; rd_wb = 4; esc_wb = 1;
    expect_out(0, 2'b01, 2'b10, 4'b0000, 3'b000, 0, 0, 0); tick();
    esc_wb = 0;
    expect_out(0, 2'b00, 2'b10, 4'b0000, 3'b000, 0, 0, 0); tick();

    // Single-bubble load-use on dut0.
    clr(); load_ex = 1; esc_ex = 1; rd_ex = 5; rt_id = 5;
    expect_out(0, 2'b00, 2'b00, 4'b1100, 3'b010, 1, 0, 0); tick();
    clr();
    expect_out(0, 2'b00, 2'b00, 4'b0000, 3'b000, 1, 1, 0); tick();
    clr(); load_ex = 1; esc_ex = 1; rd_ex = 0; rt_id = 0;
    expect_out(0, 2'b00, 2'b00, 4'b0000, 3'b000, 1, 1, 0); tick();
    clr(); load_ex = 1; esc_ex = 0; rd_ex = 5; rt_id = 5;
    expect_out(0, 2'b00, 2'b00, 4'b0000, 3'b000, 1, 1, 0); tick();
    clr(); load_ex = 0; esc_ex = 1; rd_ex = 5; rs_id = 5;
    expect_out(0, 2'b00, 2'b00, 4'b0000, 3'b000, 1, 1, 0); tick();
    clr(); hazard(5'd5);
    expect_out(0, 2'b00, 2'b00, 4'b1100, 3'b010, 1, 1, 0); tick();
    clr();
    expect_out(0, 2'b00, 2'b00, 4'b0000, 3'b000, 1, 2, 0); tick();

    // Three-bubble load-use and branch interactions on dut1.
    reset_cycle();
    hazard(5'd6); s1(4'b1100, 3'b010, 0, 0);
    clr();        s1(4'b1100, 3'b010, 1, 0);
    clr();        s1(4'b1100, 3'b010, 2, 0);
    clr();        s1(4'b0000, 3'b000, 3, 0);
    hazard(5'd6); s1(4'b1100, 3'b010, 3, 0);
    clr(); branch_ex = 1; s1(4'b0000, 3'b110, 4, 0);
    clr();        s1(4'b0000, 3'b000, 4, 1);
    hazard(5'd6); branch_ex = 1; s1(4'b0000, 3'b110, 4, 1);
    clr();        s1(4'b0000, 3'b000, 4, 2);

    // Memory wait arriving in LU_WAIT with one bubble still owed.
    hazard(5'd2); s1(4'b1100, 3'b010, 4, 2);
    clr();        s1(4'b1100, 3'b010, 5, 2);
    clr(); mem_busy = 1; s1(4'b1111, 3'b001, 6, 2);
    s1(4'b1111, 3'b001, 7, 2);
    branch_ex = 1; s1(4'b1111, 3'b001, 8, 2);
    branch_ex = 0; s1(4'b1111, 3'b001, 9, 2);
    clr();        s1(4'b0000, 3'b000, 10, 2);
    clr();        s1(4'b1100, 3'b010, 10, 2);
    clr();        s1(4'b0000, 3'b000, 11, 2);
    mem_busy = 1; s1(4'b1111, 3'b001, 11, 2);
    clr();        s1(4'b0000, 3'b000, 12, 2);
    clr();        s1(4'b0000, 3'b000, 12, 2);

    // Reset aborting LU_WAIT and MEM_WAIT.
    hazard(5'd4); s1(4'b1100, 3'b010, 12, 2);
    reset_cycle();
    s1(4'b0000, 3'b000, 0, 0);
    s1(4'b0000, 3'b000, 0, 0);
    mem_busy = 1; s1(4'b1111, 3'b001, 0, 0);
    reset_cycle();
    s1(4'b0000, 3'b000, 0, 0);

    // Counter saturation on the 4-bit dut0.
    for (int k = 0; k < 21; k++) begin
      clr(); hazard(5'd5);
      expect_out(0, 2'b00, 2'b00, 4'b1100, 3'b010, 1, (k > 15) ? 15 : k, 0);
      tick();
    end
    clr();
    expect_out(0, 2'b00, 2'b00, 4'b0000, 3'b000, 1, 15, 0); tick();
    reset_cycle();
    expect_out(0, 2'b00, 2'b00, 4'b0000, 3'b000, 1, 0, 0); tick();
    hazard(5'd5);
    expect_out(0, 2'b00, 2'b00, 4'b1100, 3'b010, 1, 0, 0); tick();
    clr();
    expect_out(0, 2'b00, 2'b00, 4'b0000, 3'b000, 1, 1, 0); tick();

    if (exp_q.size() != 0) begin
      checks++;
      failures++;
      $display("FAIL scoreboard_drain actual=%0d required=0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
